// File: rtl/hazard_scoreboard_unit.sv
// ============================================================================
// Module  : hazard_scoreboard_unit
// Brief   : RV32I hazard unit with long-op pending scoreboard, outstanding
//           counter and long-op forwarding. HAZARD_PERF_EN adds stall/flush
//           event counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard_unit #(
    parameter int REG_AW  = 5,
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              LongD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              ResultSrcEb0,
    input  logic              LongIssueE,
    input  logic              PCSrcE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              LongDoneW,
    input  logic [REG_AW-1:0] LongRdW,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              Busy,
`ifdef HAZARD_PERF_EN
    output logic [31:0]       StallCnt,
    output logic [31:0]       FlushCnt,
`endif
    output logic              ScbErr
);

    localparam int               NREG    = 1 << REG_AW;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic [NREG-1:0]  pend;
    logic [NREG-1:0]  pend_nxt;
    logic [NREG-1:0]  busy_vec;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             err_set;
    logic             slots_full;
    logic             lw_stall;
    logic             long_stall;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w,
        input logic [REG_AW-1:0] rd_l,
        input logic              we_l
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (we_m && rd_m == src)      sel = 2'b10;
            else if (we_w && rd_w == src) sel = 2'b01;
            else if (we_l && rd_l == src) sel = 2'b11;
        end
        return sel;
    endfunction

    // A completing long op releases its register in the same cycle.
    always_comb begin
        busy_vec = pend;
        if (LongDoneW) busy_vec[LongRdW] = 1'b0;
        busy_vec[0] = 1'b0;
    end

    always_comb begin
        pend_nxt = pend;
        if (LongDoneW) pend_nxt[LongRdW] = 1'b0;
        if (LongIssueE && RdE != '0) pend_nxt[RdE] = 1'b1;
        pend_nxt[0] = 1'b0;

        count_nxt = count;
        case ({LongIssueE, LongDoneW})
            2'b10:   if (count != CNT_MAX) count_nxt = count + 1'b1;
            2'b01:   if (count != '0)      count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase

        err_set = (LongDoneW && count == '0)
               || (LongDoneW && LongRdW != '0 && !pend[LongRdW])
               || (LongIssueE && count == CNT_MAX && !LongDoneW);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend   <= '0;
            count  <= '0;
            ScbErr <= 1'b0;
        end else begin
            pend  <= pend_nxt;
            count <= count_nxt;
            if (err_set) ScbErr <= 1'b1;
        end
    end

    assign slots_full = LongD && (count == CNT_MAX) && !LongDoneW;
    assign lw_stall   = ResultSrcEb0 && (Rs1D == RdE || Rs2D == RdE);
    assign long_stall = busy_vec[Rs1D] || busy_vec[Rs2D] || busy_vec[RdD]
                     || (LongIssueE && (RdE == Rs1D || RdE == Rs2D || RdE == RdD))
                     || slots_full;

    assign StallF    = lw_stall | long_stall;
    assign StallD    = lw_stall | long_stall;
    assign FlushD    = PCSrcE;
    assign FlushE    = lw_stall | long_stall | PCSrcE;
    assign Busy      = (count != '0);
    assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW, LongRdW, LongDoneW);
    assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW, LongRdW, LongDoneW);

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallD && StallCnt != '1) StallCnt <= StallCnt + 32'd1;
            if (FlushD && FlushCnt != '1) FlushCnt <= FlushCnt + 32'd1;
        end
    end
`endif

endmodule

`default_nettype wire
